fma_operand_sequencer: RTL and testbench
========================================

FMA_OPERAND_SEQUENCER -- requirements
Module: fma_operand_sequencer

Interface
REQ-001 SHALL have parameter: ISSUE_CYCLES, default 2, number of cycles fma_enable is held high per operation (legal 1..15).
REQ-002 SHALL have parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: in_valid  input  1  operand beat offered.
REQ-006 SHALL have port: in_ready  output  1  operand beat accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port: in_data  input  32  IEEE-754 single operand; beat order a, b, c.
REQ-008 SHALL have port: abort  input  1  synchronous discard of the operation in progress.
REQ-009 SHALL have port: fma_a, fma_b, fma_c  output  32 each  held operands driven to the multiply-add unit.
REQ-010 SHALL have port: fma_enable  output  1  enable to the multiply-add unit.
REQ-011 SHALL have port: fma_out  input  32  result returned by the multiply-add unit.
REQ-012 SHALL have port: res_valid  output  1  result available.
REQ-013 SHALL have port: res_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port: res_data  output  32  captured result.
REQ-015 SHALL have port: op_count  output  CNT_W  completed-operation count.

Function
REQ-016 SHALL implement FSM states S_A, S_B, S_C, S_ISSUE, S_RESULT.
REQ-017 SHALL hold in_ready high only in S_A, S_B, S_C and when abort is low.
REQ-018 SHALL, on an accepted beat, load fma_a (S_A->S_B), fma_b (S_B->S_C) or fma_c (S_C->S_ISSUE).
REQ-019 SHALL hold fma_a/b/c stable from load until the next accepted beat for the same register.
REQ-020 SHALL assert fma_enable for exactly ISSUE_CYCLES consecutive cycles in S_ISSUE, counted by a down-counter loaded on entry.
REQ-021 SHALL capture fma_out into res_data on the last S_ISSUE cycle, then move to S_RESULT.
REQ-022 SHALL hold res_valid high in S_RESULT with res_data stable until res_valid and res_ready are both high.
REQ-023 SHALL, on result handshake, increment op_count by 1 (wrapping from all-ones to 0) and return to S_A.
REQ-024 SHALL give a beat-to-result latency of ISSUE_CYCLES+1 cycles after the c beat is accepted.
REQ-025 SHALL, on abort in any state, go to S_A next cycle, deassert fma_enable and res_valid, and leave op_count unchanged.
REQ-026 SHALL give abort priority over a simultaneous result handshake or beat; neither is counted nor accepted.
REQ-027 SHALL ignore res_ready outside S_RESULT and ignore in_data while in_ready is low.

Reset
REQ-028 SHALL, while reset_n is low: state S_A, in_ready 0, fma_enable 0, res_valid 0, fma_a/b/c 0, res_data 0, op_count 0, issue counter 0.
REQ-029 SHALL, on reset mid-operation, discard operands and result with no partial handshake completion.
REQ-030 SHALL raise in_ready on the first clk edge after reset_n deasserts.

Configuration
REQ-031 SHALL, with FMA_SEQ_ZERO_BYPASS_EN defined, skip S_ISSUE when fma_a[30:23] or fma_b[30:23] is 0: res_data = fma_c on entry to S_RESULT and fma_enable stays low.
REQ-032 SHALL, without FMA_SEQ_ZERO_BYPASS_EN, always pass through S_ISSUE.

Structure
REQ-033 SHALL place the state enum, FP32_W=32 and exponent field bounds (30, 23) in package fma_pkg.
REQ-034 SHALL be a single module with no sub-module; the multiply-add unit is instantiated externally.

Verification
REQ-035 SHALL verify: beats 0x40000000, 0x40400000, 0x3F800000 with fma_out tied to a model of a*b+c -> res_data 0x40E00000 (7.0) at ISSUE_CYCLES+1 cycles after the c beat; op_count 1.
REQ-036 SHALL verify: res_ready held low 10 cycles -> res_valid and res_data stable for all 10; in_ready low for all 10.
REQ-037 SHALL verify: abort in S_C -> S_A next cycle, fma_enable never high, op_count unchanged.
REQ-038 SHALL verify: abort coincident with res_ready in S_RESULT -> no count increment, res_valid low next cycle.
REQ-039 SHALL verify: op_count preset by 2^CNT_W-1 operations, one more -> op_count 0.
REQ-040 SHALL verify: with FMA_SEQ_ZERO_BYPASS_EN, a=0x00000000, c=0x3F800000 -> res_data 0x3F800000, fma_enable never asserted.

Source files
------------

// File: rtl/fma_pkg.sv
// Shared types and constants for the FMA operand sequencer.
// Exponent field bounds feed the optional zero-exponent bypass (FMA_SEQ_ZERO_BYPASS_EN).
package fma_pkg;

  localparam int unsigned FP32_W  = 32;
  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_C,
    S_ISSUE,
    S_RESULT
  } state_t;

  // An all-zero exponent covers +/-0 and subnormals; the product is treated as zero.
  function automatic logic exp_is_zero(input logic [FP32_W-1:0] x);
    return (x[EXP_MSB:EXP_LSB] == '0);
  endfunction

endpackage

// File: rtl/fma_operand_sequencer.sv
// Collects a, b, c operand beats, pulses an external multiply-add unit, returns its result.
// Optional feature: FMA_SEQ_ZERO_BYPASS_EN returns c directly when a or b has a zero exponent.
module fma_operand_sequencer
  import fma_pkg::*;
#(
  parameter int unsigned ISSUE_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP32_W-1:0] in_data,
  input  logic              abort,
  output logic [FP32_W-1:0] fma_a,
  output logic [FP32_W-1:0] fma_b,
  output logic [FP32_W-1:0] fma_c,
  output logic              fma_enable,
  input  logic [FP32_W-1:0] fma_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [FP32_W-1:0] res_data,
  output logic [CNT_W-1:0]  op_count
);

  state_t              r_state;
  state_t              w_state_d;
  logic                r_live;
  logic [FP32_W-1:0]   r_a;
  logic [FP32_W-1:0]   r_b;
  logic [FP32_W-1:0]   r_c;
  logic [FP32_W-1:0]   r_res;
  logic [CNT_W-1:0]    r_count;
  logic [3:0]          r_issue_cnt;
  logic                w_accept;
  logic                w_bypass;
  logic                w_res_hs;
  logic                w_issue_last;

  // r_live keeps in_ready low during reset and raises it on the first edge after release.
  assign in_ready = r_live && !abort &&
                    ((r_state == S_A) || (r_state == S_B) || (r_state == S_C));
  assign w_accept     = in_valid && in_ready;
  assign w_res_hs     = (r_state == S_RESULT) && res_ready && !abort;
  assign w_issue_last = (r_state == S_ISSUE) && (r_issue_cnt == 4'd0);

`ifdef FMA_SEQ_ZERO_BYPASS_EN
  assign w_bypass = exp_is_zero(r_a) || exp_is_zero(r_b);
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    if (abort) begin
      w_state_d = S_A;
    end else begin
      case (r_state)
        S_A:      if (w_accept) w_state_d = S_B;
        S_B:      if (w_accept) w_state_d = S_C;
        S_C:      if (w_accept) w_state_d = w_bypass ? S_RESULT : S_ISSUE;
        S_ISSUE:  if (w_issue_last) w_state_d = S_RESULT;
        S_RESULT: if (res_ready) w_state_d = S_A;
        default:  w_state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_A;
      r_live      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_res       <= '0;
      r_count     <= '0;
      r_issue_cnt <= 4'd0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_d;
      if (w_accept) begin
        case (r_state)
          S_A: r_a <= in_data;
          S_B: r_b <= in_data;
          S_C: begin
            r_c         <= in_data;
            r_issue_cnt <= 4'(ISSUE_CYCLES - 1);
            if (w_bypass) r_res <= in_data;
          end
          default: ;
        endcase
      end
      if ((r_state == S_ISSUE) && !abort) begin
        if (r_issue_cnt == 4'd0) r_res <= fma_out;
        else                     r_issue_cnt <= r_issue_cnt - 4'd1;
      end
      if (w_res_hs) r_count <= r_count + 1'b1;
    end
  end

  assign fma_a      = r_a;
  assign fma_b      = r_b;
  assign fma_c      = r_c;
  assign fma_enable = (r_state == S_ISSUE);
  assign res_valid  = (r_state == S_RESULT);
  assign res_data   = r_res;
  assign op_count   = r_count;

endmodule

// File: tb/tb_fma_operand_sequencer.sv
// Scoreboard bench for fma_operand_sequencer with a real-arithmetic a*b+c model on fma_out.
// Bypass expectations switch on FMA_SEQ_ZERO_BYPASS_EN.
module tb_fma_operand_sequencer;

  localparam int unsigned ISSUE = 3;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          abort = 1'b0;
  logic [31:0]   fma_a, fma_b, fma_c;
  logic          fma_enable;
  logic [31:0]   fma_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_data;
  logic [CW-1:0] op_count;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [31:0]   sb[$];

  fma_operand_sequencer #(
    .ISSUE_CYCLES(ISSUE),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .fma_a     (fma_a),
    .fma_b     (fma_b),
    .fma_c     (fma_c),
    .fma_enable(fma_enable),
    .fma_out   (fma_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // fp32 <-> double for normal values and zero; enough for the directed vectors.
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) d = {x[31], 63'd0};
    else d = {x[31], 11'({3'd0, x[30:23]}) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  assign fma_out = r2f(f2r(fma_a) * f2r(fma_b) + f2r(fma_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready && !abort) begin
      if (sb.size() == 0) chk("unexpected_result", res_data, 32'hxxxxxxxx);
      else chk("res_data", res_data, sb.pop_front());
    end
  end

  task automatic send_beat(input logic [31:0] d);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    if (!ok) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] e, input int hold, input bit abort_res);
    int          lat;
    int          en_cnt;
    bit          byp;
    bit          stable;
    logic [31:0] held;
`ifdef FMA_SEQ_ZERO_BYPASS_EN
    byp = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
`else
    byp = 0;
`endif
    send_beat(a);
    send_beat(b);
    send_beat(c);
    lat = 1;
    en_cnt = 0;
    while (!res_valid && lat < 40) begin
      if (fma_enable) en_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, byp ? 1 : ISSUE + 1);
    chk("enable_cycles", en_cnt, byp ? 0 : ISSUE);
    held = res_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk);
      #1;
      stable = res_valid && (res_data == held) && !in_ready && (fma_a == a);
      chk("hold_stable", {31'd0, stable}, 32'd1);
    end
    in_valid = 1'b0;
    if (abort_res) begin
      abort = 1'b1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      res_ready = 1'b0;
      chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
    end else begin
      sb.push_back(e);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      exp_cnt++;
    end
    chk("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit en_seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_outputs", {fma_enable, res_valid}, 32'd0);
    chk("rst_operands", fma_a | fma_b | fma_c | res_data, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    run_op(32'h40000000, 32'h40400000, 32'h3F800000, 32'h40E00000, 0, 0);
    run_op(32'h3FC00000, 32'h40000000, 32'h3F000000, 32'h40600000, 10, 0);
    run_op(32'hBF800000, 32'h40800000, 32'h40000000, 32'hC0000000, 0, 0);

    // Abort while waiting for the c beat.
    send_beat(32'h40000000);
    send_beat(32'h40000000);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_gates_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      en_seen |= fma_enable;
    end
    chk("abort_c_enable", {31'd0, en_seen}, 32'd0);
    chk("abort_c_count", 32'(op_count), 32'(exp_cnt));
    run_op(32'h40400000, 32'h40400000, 32'h3F800000, 32'h41200000, 0, 0);

    run_op(32'h40000000, 32'h40000000, 32'h40000000, 32'h40C00000, 2, 1);
    run_op(32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 0, 0);

    // Reset in the middle of operand collection.
    send_beat(32'h40800000);
    send_beat(32'h40800000);
    reset_n = 1'b0;
    #1;
    chk("midrst_operands", fma_a | fma_b, 32'd0);
    chk("midrst_state", {in_ready, res_valid, fma_enable}, 32'd0);
    chk("midrst_count", 32'(op_count), 32'd0);
    exp_cnt = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000, 0, 0);

    while (exp_cnt != '1) run_op(32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000, 0, 0);
    chk("count_all_ones", 32'(op_count), 32'(2 ** CW - 1));
    run_op(32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000, 0, 0);
    chk("count_wrap", 32'(op_count), 32'd0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
